// File: rtl/jtag_dtm.sv
// JTAG debug transport module: oversamples the JTAG pins in the clk domain, runs the TAP,
// and turns DMI data-register scans into single debug-module read/write requests.
module jtag_dtm #(
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             jtag_tck,
  input  logic             jtag_tms,
  input  logic             jtag_tdi,
  output logic             jtag_tdo,
  output logic             dmi_valid,
  input  logic             dmi_ready,
  output logic             dmi_write,
  output logic [ABITS-1:0] dmi_addr,
  output logic [31:0]      dmi_wdata,
  input  logic [31:0]      dmi_rdata
);

  localparam int DMI_W = ABITS + 34;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_RESP} dmi_e;

  // [0] first sync stage, [1] synchronized value, [2] history
  logic [2:0] tck_q, tms_q, tdi_q;
  logic       tck_rise, tck_fall, tms_s, tdi_s;

  tap_e             tap_state, tap_next;
  logic [4:0]       ir, ir_shift;
  logic [DMI_W-1:0] dr_shift, dr_capture;
  logic [31:0]      dtmcs_value;
  logic [1:0]       dmistat, scan_op;
  logic [31:0]      result;
  dmi_e             dmi_state, dmi_next;
  logic             busy, dmi_update, dmi_issue, dtmcs_clear;

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  // tms/tdi are taken from the history stage, i.e. the value seen while tck was still low.
  assign tms_s    = tms_q[2];
  assign tdi_s    = tdi_q[2];

  always_comb begin
    // NOTE: default first so every path assigns tap_next and no latch is inferred.
    tap_next = tap_state;
    unique case (tap_state)
      TLR:     tap_next = tms_s ? TLR    : RTI;
      RTI:     tap_next = tms_s ? SEL_DR : RTI;
      SEL_DR:  tap_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:   tap_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  tap_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  tap_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = tms_s ? SEL_DR : RTI;
      SEL_IR:  tap_next = tms_s ? TLR    : CAP_IR;
      CAP_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:   tap_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  tap_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  tap_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = tms_s ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  end

  assign busy        = (dmi_state != DMI_IDLE);
  assign dmi_valid   = (dmi_state == DMI_REQ);
  assign scan_op     = dr_shift[1:0];
  assign dmi_update  = tck_rise && (tap_state == UPD_DR) && (ir == IR_DMI) &&
                       ((scan_op == 2'd1) || (scan_op == 2'd2));
  assign dmi_issue   = dmi_update && !busy && (dmistat == 2'd0);
  assign dtmcs_clear = tck_rise && (tap_state == UPD_DR) && (ir == IR_DTMCS) && dr_shift[16];
  assign dtmcs_value = {17'b0, IDLE_HINT, dmistat, 6'(ABITS), 4'd1};

  always_comb begin
    dr_capture = '0;
    unique case (ir)
      IR_IDCODE: dr_capture = DMI_W'(IDCODE);
      IR_DTMCS:  dr_capture = DMI_W'(dtmcs_value);
      IR_DMI:    dr_capture = {dmi_addr, result,
                               (busy || dmistat == 2'd3) ? 2'd3 : dmistat};
      default:   dr_capture = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tck_q     <= '0;
      tms_q     <= '0;
      tdi_q     <= '0;
      tap_state <= TLR;
      ir        <= IR_IDCODE;
      ir_shift  <= '0;
      dr_shift  <= '0;
      jtag_tdo  <= 1'b0;
    end else begin
      tck_q <= {tck_q[1:0], jtag_tck};
      tms_q <= {tms_q[1:0], jtag_tms};
      tdi_q <= {tdi_q[1:0], jtag_tdi};

      if (tck_rise) begin
        tap_state <= tap_next;
        unique case (tap_state)
          CAP_IR: ir_shift <= 5'b00001;
          SH_IR:  ir_shift <= {tdi_s, ir_shift[4:1]};
          UPD_IR: ir       <= ir_shift;
          CAP_DR: dr_shift <= dr_capture;
          SH_DR: begin
            unique case (ir)
              IR_IDCODE, IR_DTMCS: dr_shift <= DMI_W'({tdi_s, dr_shift[31:1]});
              IR_DMI:              dr_shift <= {tdi_s, dr_shift[DMI_W-1:1]};
              default:             dr_shift <= DMI_W'(tdi_s);
            endcase
          end
          default: ;
        endcase
        if (tap_next == TLR) ir <= IR_IDCODE;
      end

      if (tck_fall) begin
        if (tap_state == SH_IR)      jtag_tdo <= ir_shift[0];
        else if (tap_state == SH_DR) jtag_tdo <= dr_shift[0];
      end
    end
  end

  always_comb begin
    dmi_next = dmi_state;
    unique case (dmi_state)
      DMI_IDLE: if (dmi_issue) dmi_next = DMI_REQ;
      DMI_REQ:  if (dmi_ready) dmi_next = DMI_RESP;
      DMI_RESP: dmi_next = DMI_IDLE;
      default:  dmi_next = DMI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dmi_state <= DMI_IDLE;
      dmi_write <= 1'b0;
      dmi_addr  <= '0;
      dmi_wdata <= '0;
      result    <= '0;
      dmistat   <= 2'd0;
    end else begin
      dmi_state <= dmi_next;
      if (dmi_issue) begin
        dmi_write <= (scan_op == 2'd2);
        dmi_addr  <= dr_shift[DMI_W-1 -: ABITS];
        dmi_wdata <= dr_shift[33:2];
      end
      // The debug module presents read data one cycle after the handshake.
      if ((dmi_state == DMI_RESP) && !dmi_write) result <= dmi_rdata;
      // A scan landing while busy (including busy's last cycle) is an overrun.
      if (dmi_update && busy) dmistat <= 2'd3;
      else if (dtmcs_clear)   dmistat <= 2'd0;
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: bit-banged JTAG scans checked against a register-level
// model of the DTM and a small debug-module memory that answers DMI requests.
module tb_jtag_dtm;

  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
  localparam logic [31:0] JUNK       = 32'h0BAD_0BAD;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        jtag_tck = 1'b0, jtag_tms = 1'b0, jtag_tdi = 1'b0;
  logic        jtag_tdo;
  logic        dmi_valid, dmi_write;
  logic        dmi_ready = 1'b0;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata = JUNK;

  jtag_dtm dut (
    .clk       (clk),
    .resetn    (resetn),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_tdo  (jtag_tdo),
    .dmi_valid (dmi_valid),
    .dmi_ready (dmi_ready),
    .dmi_write (dmi_write),
    .dmi_addr  (dmi_addr),
    .dmi_wdata (dmi_wdata),
    .dmi_rdata (dmi_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the DTM's architectural state and the debug module behind it.
  logic [4:0]  m_ir;
  logic [1:0]  m_dmistat;
  bit          m_busy, m_open, m_write;
  logic [6:0]  m_req_addr;
  logic [31:0] m_req_wdata, m_result;
  logic [31:0] mem [128];
  int          hs_count = 0;

  task automatic model_reset();
    m_ir = 5'h01; m_dmistat = 2'd0; m_busy = 0; m_open = 0; m_write = 0;
    m_req_addr = '0; m_req_wdata = '0; m_result = '0;
  endtask

  function automatic int dr_len();
    case (m_ir)
      5'h01, 5'h10: return 32;
      5'h11:        return 41;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [40:0] model_capture();
    case (m_ir)
      5'h01:   return 41'(IDCODE_VAL);
      5'h10:   return 41'({17'b0, 3'd1, m_dmistat, 6'd7, 4'd1});
      5'h11:   return {m_req_addr, m_result, (m_busy || m_dmistat == 2'd3) ? 2'd3 : m_dmistat};
      default: return '0;
    endcase
  endfunction

  task automatic model_update_dr(input logic [40:0] din);
    logic [1:0] op;
    op = din[1:0];
    if (m_ir == 5'h10 && din[16]) m_dmistat = 2'd0;
    if (m_ir == 5'h11 && (op == 2'd1 || op == 2'd2)) begin
      if (m_busy) m_dmistat = 2'd3;
      else if (m_dmistat == 2'd0) begin
        m_open = 1; m_busy = 1; m_write = (op == 2'd2);
        m_req_addr = din[40:34]; m_req_wdata = din[33:2];
      end
    end
  endtask

  // Compare process and debug-module responder, one sample per clk just after the edge.
  logic prev_valid = 1'b0;
  always begin
    @(posedge clk);
    #1;
    dmi_rdata = JUNK;
    if (!resetn) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && dmi_ready) begin
        hs_count++;
        if (m_write) mem[m_req_addr] = m_req_wdata;
        else begin
          dmi_rdata = mem[m_req_addr];
          m_result  = mem[m_req_addr];
        end
        m_open = 0;
        m_busy = 0;
        check("valid_drop_after_hs", 64'(dmi_valid), 64'd0);
      end
      if (dmi_valid) begin
        check("valid_expected", 64'(m_open), 64'd1);
        check("req_write", 64'(dmi_write), 64'(m_write));
        check("req_addr",  64'(dmi_addr),  64'(m_req_addr));
        check("req_wdata", 64'(dmi_wdata), 64'(m_req_wdata));
      end
      prev_valid = dmi_valid;
    end
  end

  logic last_tdo;

  task automatic tick(input logic t_ms, input logic t_di);
    @(negedge clk);
    jtag_tms = t_ms;
    jtag_tdi = t_di;
    repeat (4) @(negedge clk);
    last_tdo = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (4) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  // From Run-Test/Idle, back to Run-Test/Idle.
  task automatic scan_ir(input logic [4:0] code);
    logic [4:0] cap;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, code[i]);
      cap[i] = last_tdo;
    end
    tick(1, 0);
    m_ir = code;
    tick(0, 0);
    check("ir_capture", 64'(cap), 64'd1);
  endtask

  task automatic scan_dr(input int len, input logic [40:0] din, output logic [40:0] dout);
    logic [40:0] cap, exp;
    int          l;
    l    = dr_len();
    cap  = model_capture();
    exp  = '0;
    dout = '0;
    for (int i = 0; i < len; i++) exp[i] = (i < l) ? cap[i] : din[i - l];
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < len; i++) begin
      tick(i == len - 1, din[i]);
      dout[i] = last_tdo;
    end
    tick(1, 0);
    if (len == l) model_update_dr(din);
    tick(0, 0);
    check("dr_scan", 64'(dout), 64'(exp));
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 50 && hs_count < target; i++) @(negedge clk);
    check("hs_count", 64'(hs_count), 64'(target));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [40:0] d;
    model_reset();
    for (int i = 0; i < 128; i++) mem[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(dmi_valid), 64'd0);
    check("rst_write", 64'(dmi_write), 64'd0);
    check("rst_addr",  64'(dmi_addr),  64'd0);
    check("rst_wdata", 64'(dmi_wdata), 64'd0);
    check("rst_tdo",   64'(jtag_tdo),  64'd0);
    resetn = 1'b1;

    // IDCODE after Test-Logic-Reset
    repeat (5) tick(1, 0);
    tick(0, 0);
    scan_dr(32, '0, d);
    check("idcode_literal", 64'(d[31:0]), 64'h1000_0001);

    // DTMCS
    scan_ir(5'h10);
    scan_dr(32, '0, d);
    check("dtmcs_literal", 64'(d[31:0]), 64'h0000_1071);

    // BYPASS: one-bit register capturing 0
    scan_ir(5'h1F);
    scan_dr(8, 41'hA5, d);
    check("bypass_literal", 64'(d[7:0]), 64'h4A);

    // DMI write held until ready
    scan_ir(5'h11);
    scan_dr(41, {7'h04, 32'hDEAD_BEEF, 2'd2}, d);
    repeat (2) @(negedge clk);
    check("wr_valid",  64'(dmi_valid), 64'd1);
    check("wr_write",  64'(dmi_write), 64'd1);
    check("wr_addr",   64'(dmi_addr),  64'h04);
    check("wr_wdata",  64'(dmi_wdata), 64'hDEAD_BEEF);
    repeat (6) @(negedge clk);
    check("wr_valid_held", 64'(dmi_valid), 64'd1);
    dmi_ready = 1'b1;
    wait_hs(1);
    repeat (3) @(negedge clk);
    check("wr_valid_done", 64'(dmi_valid), 64'd0);

    // DMI read, result shows in the following nop scan
    scan_dr(41, {7'h04, 32'h0, 2'd1}, d);
    wait_hs(2);
    repeat (3) @(negedge clk);
    scan_dr(41, '0, d);
    check("rd_data_literal", 64'(d[33:2]),  64'hDEAD_BEEF);
    check("rd_op_literal",   64'(d[1:0]),   64'd0);
    check("rd_addr_literal", 64'(d[40:34]), 64'h04);
    repeat (10) @(negedge clk);
    check("nop_no_request", 64'(hs_count), 64'd2);

    // Overrun while busy: no second request, sticky op=3
    dmi_ready = 1'b0;
    scan_dr(41, {7'h05, 32'h1234_5678, 2'd2}, d);
    scan_dr(41, {7'h06, 32'hCAFE_F00D, 2'd2}, d);
    check("busy_op_literal",   64'(d[1:0]),  64'd3);
    check("busy_addr_held",    64'(dmi_addr), 64'h05);
    dmi_ready = 1'b1;
    wait_hs(3);
    repeat (3) @(negedge clk);
    scan_dr(41, '0, d);
    check("sticky_op_literal", 64'(d[1:0]), 64'd3);
    repeat (10) @(negedge clk);
    check("overrun_not_issued", 64'(hs_count), 64'd3);

    // dmireset through DTMCS
    scan_ir(5'h10);
    scan_dr(32, 41'h1_0000, d);
    check("dtmcs_stat3_literal", 64'(d[31:0]), 64'h0000_1C71);
    scan_dr(32, '0, d);
    check("dtmcs_clear_literal", 64'(d[31:0]), 64'h0000_1071);

    // Next write issues again; then reset with the request pending
    scan_ir(5'h11);
    dmi_ready = 1'b0;
    scan_dr(41, {7'h06, 32'hCAFE_F00D, 2'd2}, d);
    repeat (2) @(negedge clk);
    check("rewrite_valid", 64'(dmi_valid), 64'd1);
    check("rewrite_addr",  64'(dmi_addr),  64'h06);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_reset_valid", 64'(dmi_valid), 64'd0);
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    tick(0, 0);
    scan_dr(32, '0, d);
    check("idcode_after_reset", 64'(d[31:0]), 64'(IDCODE_VAL));

    // Five tms=1 from Shift-IR reach Test-Logic-Reset and reload IDCODE
    scan_ir(5'h11);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (5) tick(1, 1);
    m_ir = 5'h01;
    tick(0, 0);
    scan_dr(32, '0, d);
    check("idcode_after_tlr", 64'(d[31:0]), 64'h1000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
